// File: rtl/reg_arb_pkg.sv
// Shared types and default widths for the register-file write arbiter.
package reg_arb_pkg;

    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefAddrW = 3;

    // Requester identity; also the encoding of the round-robin pointer.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LD  = 1'b1
    } req_id_e;

    // One-entry holding buffer per requester.
    typedef struct packed {
        logic                full;
        logic [DefAddrW-1:0] addr;
        logic [DefDataW-1:0] data;
    } buf_entry_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from two request bits, pointer
// moves to the losing requester after every grant.
module rr_arb2
    import reg_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    req_id_e ptr_q, ptr_d;

    // Grant: a lone request wins outright, a tie goes to the pointer.
    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (ptr_q == REQ_ALU) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    // Pointer next state: favour the requester that just lost.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_o[0]) begin
            ptr_d = REQ_LD;
        end else if (gnt_o[1]) begin
            ptr_d = REQ_ALU;
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= REQ_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates the register file's single write port between the ALU and load
// writeback paths, with one-entry buffers and a per-register busy scoreboard.
// Define REG_SCOREBOARD_EN to build the BUSY scoreboard; otherwise BUSY is 0.
// Buffer entries use the package default widths, so DATA_W/ADDR_W must match
// DefDataW/DefAddrW.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   ALU_VALID,
    output logic                   ALU_READY,
    input  logic [ADDR_W-1:0]      ALU_ADDR,
    input  logic [DATA_W-1:0]      ALU_DATA,
    input  logic                   LD_VALID,
    output logic                   LD_READY,
    input  logic [ADDR_W-1:0]      LD_ADDR,
    input  logic [DATA_W-1:0]      LD_DATA,
    output logic                   WRITE,
    output logic [DATA_W-1:0]      IN,
    output logic [ADDR_W-1:0]      INADDRESS,
    output logic [(1<<ADDR_W)-1:0] BUSY
);

    buf_entry_t        alu_q, alu_d;
    buf_entry_t        ld_q, ld_d;
    logic [1:0]        gnt;
    logic              rdy_en_q;
    logic              write_q, write_d;
    logic [DATA_W-1:0] in_q, in_d;
    logic [ADDR_W-1:0] inaddr_q, inaddr_d;

    rr_arb2 u_rr_arb2 (
        .clk_i  (CLK),
        .rst_ni (RESET_N),
        .req_i  ({ld_q.full, alu_q.full}),
        .gnt_o  (gnt)
    );

    // READY depends only on full flags, grant and the post-reset enable.
    always_comb begin
        ALU_READY = rdy_en_q && (!alu_q.full || gnt[0]);
        LD_READY  = rdy_en_q && (!ld_q.full || gnt[1]);
    end

    // Buffer next state: accept wins over drain so a granted buffer can refill.
    always_comb begin
        alu_d = alu_q;
        ld_d  = ld_q;
        if (ALU_VALID && ALU_READY) begin
            alu_d = '{full: 1'b1, addr: ALU_ADDR, data: ALU_DATA};
        end else if (gnt[0]) begin
            alu_d.full = 1'b0;
        end
        if (LD_VALID && LD_READY) begin
            ld_d = '{full: 1'b1, addr: LD_ADDR, data: LD_DATA};
        end else if (gnt[1]) begin
            ld_d.full = 1'b0;
        end
    end

    // Issue next state: present the granted entry, otherwise hold IN/INADDRESS.
    always_comb begin
        write_d  = |gnt;
        in_d     = in_q;
        inaddr_d = inaddr_q;
        if (gnt[0]) begin
            in_d     = alu_q.data;
            inaddr_d = alu_q.addr;
        end else if (gnt[1]) begin
            in_d     = ld_q.data;
            inaddr_d = ld_q.addr;
        end
    end

    // State registers; reset discards anything pending.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            alu_q    <= '0;
            ld_q     <= '0;
            rdy_en_q <= 1'b0;
            write_q  <= 1'b0;
            in_q     <= '0;
            inaddr_q <= '0;
        end else begin
            alu_q    <= alu_d;
            ld_q     <= ld_d;
            rdy_en_q <= 1'b1;
            write_q  <= write_d;
            in_q     <= in_d;
            inaddr_q <= inaddr_d;
        end
    end

    assign WRITE     = write_q;
    assign IN        = in_q;
    assign INADDRESS = inaddr_q;

`ifdef REG_SCOREBOARD_EN
    // Scoreboard: a register is busy while buffered or on the write port.
    always_comb begin
        BUSY = '0;
        for (int r = 0; r < (1 << ADDR_W); r++) begin
            BUSY[r] = (alu_q.full && (alu_q.addr == ADDR_W'(r))) ||
                      (ld_q.full && (ld_q.addr == ADDR_W'(r))) ||
                      (write_q && (inaddr_q == ADDR_W'(r)));
        end
    end
`else
    assign BUSY = '0;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: a transaction-level model of the
// two buffers, round-robin pointer, write port and register file is compared
// against the DUT every cycle under directed and random stimulus.
module tb_reg_write_arbiter;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       ALU_VALID = 1'b0;
    logic       ALU_READY;
    logic [2:0] ALU_ADDR = '0;
    logic [7:0] ALU_DATA = '0;
    logic       LD_VALID = 1'b0;
    logic       LD_READY;
    logic [2:0] LD_ADDR = '0;
    logic [7:0] LD_DATA = '0;
    logic       WRITE;
    logic [7:0] IN;
    logic [2:0] INADDRESS;
    logic [7:0] BUSY;

    reg_write_arbiter dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .ALU_VALID (ALU_VALID),
        .ALU_READY (ALU_READY),
        .ALU_ADDR  (ALU_ADDR),
        .ALU_DATA  (ALU_DATA),
        .LD_VALID  (LD_VALID),
        .LD_READY  (LD_READY),
        .LD_ADDR   (LD_ADDR),
        .LD_DATA   (LD_DATA),
        .WRITE     (WRITE),
        .IN        (IN),
        .INADDRESS (INADDRESS),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    // Model: pending entry per source, whose turn it is on a tie, the write
    // currently on the port, and the register file contents.
    bit         m_full[2];
    logic [2:0] m_addr[2];
    logic [7:0] m_data[2];
    int         m_turn;
    bit         m_write;
    logic [7:0] m_in;
    logic [2:0] m_inaddr;
    logic [7:0] m_regs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_full[0] = 0;
        m_full[1] = 0;
        m_addr[0] = '0;
        m_addr[1] = '0;
        m_data[0] = '0;
        m_data[1] = '0;
        m_turn    = 0;
        m_write   = 0;
        m_in      = '0;
        m_inaddr  = '0;
    endtask

    // One cycle: drive inputs just after the falling edge, compare outputs,
    // then advance the model across the rising edge.
    task automatic step(input bit v0, input logic [2:0] a0, input logic [7:0] d0,
                        input bit v1, input logic [2:0] a1, input logic [7:0] d1);
        int         g;
        bit         rdy[2];
        bit         vld[2];
        logic [2:0] adr[2];
        logic [7:0] dat[2];
        logic [7:0] eb;
        ALU_VALID = v0;
        ALU_ADDR  = a0;
        ALU_DATA  = d0;
        LD_VALID  = v1;
        LD_ADDR   = a1;
        LD_DATA   = d1;
        vld[0] = v0; adr[0] = a0; dat[0] = d0;
        vld[1] = v1; adr[1] = a1; dat[1] = d1;
        #1;
        if (m_full[0] && m_full[1]) g = m_turn;
        else if (m_full[0])         g = 0;
        else if (m_full[1])         g = 1;
        else                        g = -1;
        for (int i = 0; i < 2; i++) rdy[i] = !m_full[i] || (g == i);
        eb = '0;
`ifdef REG_SCOREBOARD_EN
        for (int r = 0; r < 8; r++) begin
            eb[r] = (m_full[0] && m_addr[0] == 3'(r)) || (m_full[1] && m_addr[1] == 3'(r)) ||
                    (m_write && m_inaddr == 3'(r));
        end
`endif
        chk("alu_ready", 32'(ALU_READY), 32'(rdy[0]));
        chk("ld_ready", 32'(LD_READY), 32'(rdy[1]));
        chk("write", 32'(WRITE), 32'(m_write));
        chk("in", 32'(IN), 32'(m_in));
        chk("inaddress", 32'(INADDRESS), 32'(m_inaddr));
        chk("busy", 32'(BUSY), 32'(eb));
        @(posedge CLK);
        if (m_write) m_regs[m_inaddr] = m_in;
        if (g >= 0) begin
            m_write  = 1;
            m_in     = m_data[g];
            m_inaddr = m_addr[g];
            m_turn   = 1 - g;
        end else begin
            m_write = 0;
        end
        for (int i = 0; i < 2; i++) begin
            if (vld[i] && rdy[i]) begin
                m_full[i] = 1;
                m_addr[i] = adr[i];
                m_data[i] = dat[i];
            end else if (g == i) begin
                m_full[i] = 0;
            end
        end
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 3'd0, 8'd0, 0, 3'd0, 8'd0);
    endtask

    // Assert reset mid-cycle, check outputs drop at once, then release.
    task automatic pulse_reset(input string tag);
        ALU_VALID = 0;
        LD_VALID  = 0;
        #2;
        RESET_N = 0;
        #1;
        chk({tag, "_rst_alu_ready"}, 32'(ALU_READY), 0);
        chk({tag, "_rst_ld_ready"}, 32'(LD_READY), 0);
        chk({tag, "_rst_write"}, 32'(WRITE), 0);
        chk({tag, "_rst_busy"}, 32'(BUSY), 0);
        chk({tag, "_rst_inaddr"}, 32'(INADDRESS), 0);
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        #2;
        RESET_N = 1;
        @(negedge CLK);
    endtask

    int cnt;

    initial begin
        for (int r = 0; r < 8; r++) m_regs[r] = 'x;
        model_reset();
        @(negedge CLK);
        pulse_reset("init");

        // Single request.
        step(1, 3'd3, 8'h5A, 0, 3'd0, 8'h00);
        step(0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
        chk("single_write", 32'(WRITE), 1);
        chk("single_in", 32'(IN), 32'h5A);
        chk("single_addr", 32'(INADDRESS), 3);
        idle(3);
        chk("single_regfile", 32'(m_regs[3]), 32'h5A);
        chk("single_idle_write", 32'(WRITE), 0);

        // Contention from reset, both held valid: ALU first, then load.
        pulse_reset("cont");
        step(1, 3'd1, 8'h11, 1, 3'd2, 8'h22);
        step(1, 3'd1, 8'h11, 1, 3'd2, 8'h22);
        chk("cont_first_in", 32'(IN), 32'h11);
        chk("cont_first_addr", 32'(INADDRESS), 1);
        step(1, 3'd1, 8'h11, 1, 3'd2, 8'h22);
        chk("cont_second_in", 32'(IN), 32'h22);
        chk("cont_second_addr", 32'(INADDRESS), 2);
        step(1, 3'd1, 8'h11, 1, 3'd2, 8'h22);
        step(0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
        idle(4);

        // Same address from both sources on one edge: last write wins.
        pulse_reset("same");
        step(1, 3'd4, 8'hAA, 1, 3'd4, 8'hBB);
        step(0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
        chk("same_first_in", 32'(IN), 32'hAA);
        step(0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
        chk("same_second_in", 32'(IN), 32'hBB);
        idle(3);
        chk("same_regfile", 32'(m_regs[4]), 32'hBB);

        // Back-to-back ALU writes, load idle.
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, 3'(i), 8'(8'h30 + i), 0, 3'd0, 8'h00);
            if (WRITE) cnt++;
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
            if (WRITE) cnt++;
        end
        chk("b2b_write_count", 32'(cnt), 4);

        // Reset while both buffers are full and a write is on the port.
        step(1, 3'd5, 8'h55, 1, 3'd6, 8'h66);
        step(1, 3'd7, 8'h77, 1, 3'd6, 8'h66);
        chk("midrst_pre_write", 32'(WRITE), 1);
        pulse_reset("midrst");
        idle(4);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 6), 3'($urandom_range(0, 7)), 8'($urandom),
                 ($urandom_range(0, 9) < 6), 3'($urandom_range(0, 7)), 8'($urandom));
            if (i == 200) pulse_reset("rand");
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
